// File: rtl/e203_exu_wfi_ctrl_pkg.sv
// Shared types and constants for the E203 WFI sleep controller.
// Holds the controller state encoding and the wake-source reduction.
package e203_exu_wfi_ctrl_pkg;

    localparam int unsigned E203_LIRQ_NUM = 1;
    localparam int unsigned E203_WFI_ST_W = 3;

    typedef enum logic [E203_WFI_ST_W-1:0] {
        E203_WFI_ST_IDLE  = 3'd0,
        E203_WFI_ST_DRAIN = 3'd1,
        E203_WFI_ST_HALT  = 3'd2,
        E203_WFI_ST_SLEEP = 3'd3,
        E203_WFI_ST_WAKE  = 3'd4
    } wfi_state_e;

    // Wake ignores the global MIE bit on purpose: WFI must resume on any locally enabled pending interrupt.
    function automatic logic wfi_wake(
        input logic ext_irq,
        input logic meie,
        input logic sft_irq,
        input logic msie,
        input logic tmr_irq,
        input logic mtie,
        input logic lcl_any,
        input logic dbg_irq,
        input logic dbg_halt
    );
        return (ext_irq & meie) | (sft_irq & msie) | (tmr_irq & mtie)
             | lcl_any | dbg_irq | dbg_halt;
    endfunction

endpackage

// File: rtl/e203_exu_wfi_satcnt.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module e203_exu_wfi_satcnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic at_max;

    assign at_max = (cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/e203_exu_wfi_ctrl.sv
// WFI sleep sequencer: drain long-pipe ops, halt IFU/EXU via req/ack,
// sleep until a wake event, then release the halts after a restart delay.
module e203_exu_wfi_ctrl
    import e203_exu_wfi_ctrl_pkg::*;
#(
    parameter int unsigned WAKE_DLY = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wfi_req_valid,
    output logic                     wfi_req_ready,
    input  logic                     dbg_mode,
    input  logic                     oitf_empty,
    input  logic                     amo_wait,
    output logic                     wfi_halt_ifu_req,
    input  logic                     wfi_halt_ifu_ack,
    output logic                     wfi_halt_exu_req,
    input  logic                     wfi_halt_exu_ack,
    input  logic                     ext_irq_r,
    input  logic                     sft_irq_r,
    input  logic                     tmr_irq_r,
    input  logic                     meie_r,
    input  logic                     msie_r,
    input  logic                     mtie_r,
    input  logic [E203_LIRQ_NUM-1:0] lcl_irq_r,
    input  logic                     dbg_irq_r,
    input  logic                     dbg_halt_r,
    output logic                     core_wfi,
    output logic                     wake_pulse,
    output logic [CNT_W-1:0]         sleep_cnt,
    input  logic                     sleep_cnt_clr
);

    localparam int unsigned DLY_W = $clog2(WAKE_DLY + 1);

    wfi_state_e       state;
    wfi_state_e       nxt_state;
    logic             wake;
    logic             req_fire;
    logic             ifu_ack_q;
    logic             exu_ack_q;
    logic             ifu_done;
    logic             exu_done;
    logic [DLY_W-1:0] dly_cnt;
    logic             dly_last;
    logic             sleep_inc;

    assign wake = wfi_wake(ext_irq_r, meie_r, sft_irq_r, msie_r, tmr_irq_r, mtie_r,
                           |lcl_irq_r, dbg_irq_r, dbg_halt_r);

    assign req_fire = wfi_req_valid & wfi_req_ready;

    // Current-cycle ack counts too, so an ack never costs an extra cycle.
    assign ifu_done = ifu_ack_q | wfi_halt_ifu_ack;
    assign exu_done = exu_ack_q | wfi_halt_exu_ack;
    assign dly_last = (dly_cnt == DLY_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= E203_WFI_ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state logic; wake always wins over drain/ack progress.
    always_comb begin
        nxt_state = state;
        case (state)
            E203_WFI_ST_IDLE: begin
                if (req_fire && !dbg_mode && !wake) begin
                    nxt_state = E203_WFI_ST_DRAIN;
                end
            end
            E203_WFI_ST_DRAIN: begin
                if (wake) begin
                    nxt_state = E203_WFI_ST_IDLE;
                end else if (oitf_empty && !amo_wait) begin
                    nxt_state = E203_WFI_ST_HALT;
                end
            end
            E203_WFI_ST_HALT: begin
                if (wake) begin
                    nxt_state = E203_WFI_ST_WAKE;
                end else if (ifu_done && exu_done) begin
                    nxt_state = E203_WFI_ST_SLEEP;
                end
            end
            E203_WFI_ST_SLEEP: begin
                if (wake) begin
                    nxt_state = E203_WFI_ST_WAKE;
                end
            end
            E203_WFI_ST_WAKE: begin
                if (dly_last) begin
                    nxt_state = E203_WFI_ST_IDLE;
                end
            end
            default: nxt_state = E203_WFI_ST_IDLE;
        endcase
    end

    // Outputs decode the state register only, so they cannot glitch.
    always_comb begin
        wfi_req_ready    = 1'b0;
        wfi_halt_ifu_req = 1'b0;
        wfi_halt_exu_req = 1'b0;
        core_wfi         = 1'b0;
        sleep_inc        = 1'b0;
        case (state)
            E203_WFI_ST_IDLE: begin
                wfi_req_ready = 1'b1;
            end
            E203_WFI_ST_HALT,
            E203_WFI_ST_WAKE: begin
                wfi_halt_ifu_req = 1'b1;
                wfi_halt_exu_req = 1'b1;
            end
            E203_WFI_ST_SLEEP: begin
                wfi_halt_ifu_req = 1'b1;
                wfi_halt_exu_req = 1'b1;
                core_wfi         = 1'b1;
                sleep_inc        = 1'b1;
            end
            default: begin
                wfi_req_ready = 1'b0;
            end
        endcase
    end

    // Sticky acks: set while the matching halt is requested, cleared in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifu_ack_q <= 1'b0;
            exu_ack_q <= 1'b0;
        end else if (state == E203_WFI_ST_IDLE) begin
            ifu_ack_q <= 1'b0;
            exu_ack_q <= 1'b0;
        end else begin
            if (wfi_halt_ifu_req && wfi_halt_ifu_ack) begin
                ifu_ack_q <= 1'b1;
            end
            if (wfi_halt_exu_req && wfi_halt_exu_ack) begin
                exu_ack_q <= 1'b1;
            end
        end
    end

    // Restart delay: loaded on WAKE entry, counts down to 1 before release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_cnt <= '0;
        end else if ((state != E203_WFI_ST_WAKE) && (nxt_state == E203_WFI_ST_WAKE)) begin
            dly_cnt <= DLY_W'(WAKE_DLY);
        end else if ((state == E203_WFI_ST_WAKE) && (dly_cnt != '0)) begin
            dly_cnt <= dly_cnt - DLY_W'(1);
        end
    end

    // Strobe coincides with the first IDLE cycle after WAKE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wake_pulse <= 1'b0;
        end else begin
            wake_pulse <= (state == E203_WFI_ST_WAKE) && (nxt_state == E203_WFI_ST_IDLE);
        end
    end

    e203_exu_wfi_satcnt #(
        .CNT_W (CNT_W)
    ) u_sleep_cnt (
        .clk (clk),
        .rst (rst),
        .inc (sleep_inc),
        .clr (sleep_cnt_clr),
        .cnt (sleep_cnt)
    );

endmodule

// File: tb/tb_e203_exu_wfi_ctrl.sv
// Bench for e203_exu_wfi_ctrl: directed table, corner sequences and random
// traffic checked against a behavioural model of the sleep handshake.
module tb_e203_exu_wfi_ctrl;
    import e203_exu_wfi_ctrl_pkg::*;

    localparam int unsigned WAKE_DLY = 2;

    logic clk = 1'b0;
    logic rst;
    logic wfi_req_valid, dbg_mode, oitf_empty, amo_wait;
    logic ack_i, ack_e;
    logic ext_irq_r, sft_irq_r, tmr_irq_r, meie_r, msie_r, mtie_r;
    logic [E203_LIRQ_NUM-1:0] lcl_irq_r;
    logic dbg_irq_r, dbg_halt_r, sleep_cnt_clr;

    logic        ready, ifu_req, exu_req, core_wfi, wake_pulse;
    logic [31:0] cnt32;
    logic        ready4, ifu_req4, exu_req4, core_wfi4, wake_pulse4;
    logic [3:0]  cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    e203_exu_wfi_ctrl #(.WAKE_DLY(WAKE_DLY), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .wfi_req_valid(wfi_req_valid), .wfi_req_ready(ready), .dbg_mode(dbg_mode),
        .oitf_empty(oitf_empty), .amo_wait(amo_wait),
        .wfi_halt_ifu_req(ifu_req), .wfi_halt_ifu_ack(ack_i),
        .wfi_halt_exu_req(exu_req), .wfi_halt_exu_ack(ack_e),
        .ext_irq_r(ext_irq_r), .sft_irq_r(sft_irq_r), .tmr_irq_r(tmr_irq_r),
        .meie_r(meie_r), .msie_r(msie_r), .mtie_r(mtie_r), .lcl_irq_r(lcl_irq_r),
        .dbg_irq_r(dbg_irq_r), .dbg_halt_r(dbg_halt_r),
        .core_wfi(core_wfi), .wake_pulse(wake_pulse),
        .sleep_cnt(cnt32), .sleep_cnt_clr(sleep_cnt_clr)
    );

    e203_exu_wfi_ctrl #(.WAKE_DLY(WAKE_DLY), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .wfi_req_valid(wfi_req_valid), .wfi_req_ready(ready4), .dbg_mode(dbg_mode),
        .oitf_empty(oitf_empty), .amo_wait(amo_wait),
        .wfi_halt_ifu_req(ifu_req4), .wfi_halt_ifu_ack(ack_i),
        .wfi_halt_exu_req(exu_req4), .wfi_halt_exu_ack(ack_e),
        .ext_irq_r(ext_irq_r), .sft_irq_r(sft_irq_r), .tmr_irq_r(tmr_irq_r),
        .meie_r(meie_r), .msie_r(msie_r), .mtie_r(mtie_r), .lcl_irq_r(lcl_irq_r),
        .dbg_irq_r(dbg_irq_r), .dbg_halt_r(dbg_halt_r),
        .core_wfi(core_wfi4), .wake_pulse(wake_pulse4),
        .sleep_cnt(cnt4), .sleep_cnt_clr(sleep_cnt_clr)
    );

    // Behavioural model: phase of the handshake plus absolute bookkeeping.
    typedef enum int {P_RUN, P_DRAIN, P_HALTING, P_ASLEEP, P_WAKING} phase_e;
    phase_e m_ph;
    bit     m_ifu_seen, m_exu_seen, m_pulse;
    int     m_left;
    longint m_cnt;

    typedef struct {
        logic       valid;
        logic       ack_i;
        logic       ack_e;
        logic       tmr;
        logic [4:0] flags;   // {ready, ifu_req, exu_req, core_wfi, wake_pulse}
        int         cnt;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_wake();
        return bit'((ext_irq_r & meie_r) | (sft_irq_r & msie_r) | (tmr_irq_r & mtie_r)
                  | (|lcl_irq_r) | dbg_irq_r | dbg_halt_r);
    endfunction

    task automatic model_reset();
        m_ph = P_RUN; m_ifu_seen = 0; m_exu_seen = 0; m_pulse = 0; m_left = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit w;
        phase_e ph;
        w = model_wake();
        ph = m_ph;
        m_pulse = 0;
        if (sleep_cnt_clr) m_cnt = 0;
        else if (ph == P_ASLEEP) m_cnt++;
        case (ph)
            P_RUN: begin
                m_ifu_seen = 0; m_exu_seen = 0;
                if (wfi_req_valid && !dbg_mode && !w) m_ph = P_DRAIN;
            end
            P_DRAIN: begin
                if (w) m_ph = P_RUN;
                else if (oitf_empty && !amo_wait) m_ph = P_HALTING;
            end
            P_HALTING: begin
                m_ifu_seen |= bit'(ack_i);
                m_exu_seen |= bit'(ack_e);
                if (w) begin m_ph = P_WAKING; m_left = WAKE_DLY; end
                else if (m_ifu_seen && m_exu_seen) m_ph = P_ASLEEP;
            end
            P_ASLEEP: begin
                if (w) begin m_ph = P_WAKING; m_left = WAKE_DLY; end
            end
            P_WAKING: begin
                m_left--;
                if (m_left == 0) begin m_ph = P_RUN; m_pulse = 1; end
            end
            default: m_ph = P_RUN;
        endcase
    endtask

    task automatic check_model();
        bit halted;
        logic [4:0] exp_flags;
        halted = (m_ph == P_HALTING) || (m_ph == P_ASLEEP) || (m_ph == P_WAKING);
        exp_flags = {m_ph == P_RUN, halted, halted, m_ph == P_ASLEEP, m_pulse};
        check("model_flags", 64'({ready, ifu_req, exu_req, core_wfi, wake_pulse}), 64'(exp_flags));
        check("model_cnt32", 64'(cnt32), 64'((m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt));
        check("model_cnt4", 64'(cnt4), 64'((m_cnt > 15) ? 15 : m_cnt));
    endtask

    // One clock: model follows the edge, outputs are checked mid-low-phase.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic quiet_inputs();
        wfi_req_valid = 0; dbg_mode = 0; oitf_empty = 1; amo_wait = 0;
        ack_i = 0; ack_e = 0;
        ext_irq_r = 0; sft_irq_r = 0; tmr_irq_r = 0;
        meie_r = 0; msie_r = 0; mtie_r = 0; lcl_irq_r = '0;
        dbg_irq_r = 0; dbg_halt_r = 0; sleep_cnt_clr = 0;
    endtask

    initial begin
        // Basic sleep: fire at row 0, IFU ack row 3, EXU ack row 5, timer wake row 10.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b10000, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01100, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b01100, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01100, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b01100, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01110, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01110, 1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01110, 2};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01110, 3};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b01110, 4};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01100, 5};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01100, 5};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10001, 5};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10000, 5};

        quiet_inputs();
        rst = 1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_flags", 64'({ready, ifu_req, exu_req, core_wfi, wake_pulse}), 64'(5'b10000));
        check("reset_cnt", 64'(cnt32), 64'd0);
        rst = 0;

        // Directed table.
        mtie_r = 1;
        for (int i = 0; i < 15; i++) begin
            wfi_req_valid = tbl[i].valid;
            ack_i = tbl[i].ack_i;
            ack_e = tbl[i].ack_e;
            tmr_irq_r = tbl[i].tmr;
            check($sformatf("basic_flags[%0d]", i),
                  64'({ready, ifu_req, exu_req, core_wfi, wake_pulse}), 64'(tbl[i].flags));
            check($sformatf("basic_cnt[%0d]", i), 64'(cnt32), 64'(tbl[i].cnt));
            tick();
        end
        quiet_inputs();

        // Debug-mode WFI completes as a NOP.
        dbg_mode = 1; wfi_req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dbg_nop", 64'({ready, ifu_req, exu_req}), 64'(3'b100));
        end
        quiet_inputs();
        tick();

        // Drain holds off halting while long-pipe work or an AMO is pending.
        wfi_req_valid = 1; oitf_empty = 0; amo_wait = 1;
        tick();
        wfi_req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_hold", 64'({ready, ifu_req, exu_req}), 64'(3'b000));
        end
        oitf_empty = 1; amo_wait = 0;
        tick();
        check("drain_release", 64'({ifu_req, exu_req}), 64'(2'b11));
        dbg_halt_r = 1;
        tick();
        dbg_halt_r = 0;
        repeat (2) tick();
        check("drain_wake_pulse", 64'(wake_pulse), 64'd1);

        // Wake during DRAIN aborts without ever raising the halts.
        wfi_req_valid = 1; oitf_empty = 0;
        tick();
        wfi_req_valid = 0; ext_irq_r = 1; meie_r = 1;
        tick();
        check("abort_idle", 64'({ready, ifu_req, exu_req, wake_pulse}), 64'(4'b1000));
        quiet_inputs();
        tick();
        check("abort_no_pulse", 64'(wake_pulse), 64'd0);

        // Wake coinciding with both acks in HALT goes straight to WAKE.
        wfi_req_valid = 1;
        tick();
        wfi_req_valid = 0;
        tick();
        ack_i = 1; ack_e = 1; dbg_halt_r = 1;
        tick();
        check("race_wake", 64'({ready, ifu_req, exu_req, core_wfi}), 64'(4'b0110));
        quiet_inputs();
        tick();
        check("race_no_wfi", 64'(core_wfi), 64'd0);
        tick();
        check("race_pulse", 64'({ready, wake_pulse}), 64'(2'b11));

        // Counter saturation and clear-in-sleep.
        sleep_cnt_clr = 1;
        tick();
        sleep_cnt_clr = 0;
        wfi_req_valid = 1;
        tick();
        wfi_req_valid = 0;
        tick();
        ack_i = 1; ack_e = 1;
        tick();
        ack_i = 0; ack_e = 0;
        repeat (20) tick();
        check("sat4", 64'(cnt4), 64'd15);
        check("cnt32_20", 64'(cnt32), 64'd20);
        sleep_cnt_clr = 1;
        tick();
        sleep_cnt_clr = 0;
        check("clr_in_sleep", 64'({cnt4, cnt32}), 64'd0);
        tick();
        check("sleep_before_rst", 64'(core_wfi), 64'd1);

        // Async reset while asleep drops everything without a clock edge.
        rst = 1;
        #1;
        check("async_rst", 64'({ready, ifu_req, exu_req, core_wfi, wake_pulse}), 64'(5'b10000));
        check("async_rst_cnt", 64'(cnt32), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            wfi_req_valid = 1'($urandom_range(0, 1));
            dbg_mode      = ($urandom_range(0, 9) == 0);
            oitf_empty    = ($urandom_range(0, 3) != 0);
            amo_wait      = ($urandom_range(0, 3) == 0);
            ack_i         = ($urandom_range(0, 3) == 0);
            ack_e         = ($urandom_range(0, 3) == 0);
            ext_irq_r     = ($urandom_range(0, 15) == 0);
            sft_irq_r     = ($urandom_range(0, 15) == 0);
            tmr_irq_r     = ($urandom_range(0, 15) == 0);
            meie_r        = 1'($urandom_range(0, 1));
            msie_r        = 1'($urandom_range(0, 1));
            mtie_r        = 1'($urandom_range(0, 1));
            lcl_irq_r     = E203_LIRQ_NUM'(($urandom_range(0, 63) == 0) ? 1 : 0);
            dbg_irq_r     = ($urandom_range(0, 63) == 0);
            dbg_halt_r    = ($urandom_range(0, 63) == 0);
            sleep_cnt_clr = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
